vdp_cpu_port: RTL and testbench



---
 rtl/vdp_pkg.sv | 19 +
 rtl/vdp_addr_latch.sv | 62 ++++++
 rtl/vdp_cpu_port.sv | 169 ++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU-side access controller: FSM encoding,
// default widths and control-byte command bit positions.
package vdp_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int REG_W_DEF  = 3;

  // Second control byte: bit 7 selects a register write, bit 6 a VRAM write setup.
  localparam int CMD_REG = 7;
  localparam int CMD_WR  = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    FETCH   = 2'd2,
    CAPTURE = 2'd3
  } vdp_state_e;

endpackage

// File: rtl/vdp_addr_latch.sv
// Two-byte control latch, first/second byte flag and the auto-incrementing
// VRAM pointer (wraps modulo 2^ADDR_W).
module vdp_addr_latch
  import vdp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              latch_we,
  input  logic [7:0]        latch_din,
  input  logic              flag_set,
  input  logic              flag_clr,
  input  logic              ptr_load,
  input  logic [ADDR_W-9:0] ptr_hi,
  input  logic              ptr_inc,
  output logic [7:0]        latch,
  output logic              flag,
  output logic [ADDR_W-1:0] ptr
);

  logic [7:0]        latch_q, latch_d;
  logic              flag_q, flag_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    latch_d = latch_q;
    flag_d  = flag_q;
    ptr_d   = ptr_q;
    if (latch_we) begin
      latch_d = latch_din;
    end
    if (flag_set) begin
      flag_d = 1'b1;
    end else if (flag_clr) begin
      flag_d = 1'b0;
    end
    // Load and increment never coincide: loads happen in IDLE only.
    if (ptr_load) begin
      ptr_d = {ptr_hi, latch_q};
    end else if (ptr_inc) begin
      ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= '0;
      flag_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      latch_q <= latch_d;
      flag_q  <= flag_d;
      ptr_q   <= ptr_d;
    end
  end

  assign latch = latch_q;
  assign flag  = flag_q;
  assign ptr   = ptr_q;

endmodule

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU port: decodes data/control strobes, sequences VRAM port A
// and emits register writes. Define VDP_WRBUF_EN to let data writes refill the read buffer.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic              cpu_mode,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              ready,
  input  logic [7:0]        status_in,
  output logic              status_rd,
  output logic              reg_we,
  output logic [REG_W-1:0]  reg_num,
  output logic [7:0]        reg_data,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_din,
  input  logic [7:0]        vram_dout,
  output logic [1:0]        dbg_state
);

  // Handshake: a strobe (cpu_wr or cpu_rd, one cycle) is accepted on the edge
  // where ready=1; strobes seen while ready=0 are dropped, and when both are
  // high the write is taken and the read discarded.

  vdp_state_e       state_q, state_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rbuf_q, rbuf_d;
  logic [7:0]       cpu_dout_q, cpu_dout_d;
  logic             reg_we_q, reg_we_d;
  logic [REG_W-1:0] reg_num_q, reg_num_d;
  logic [7:0]       reg_data_q, reg_data_d;
  logic             status_rd_q, status_rd_d;

  logic              latch_we, flag_set, flag_clr, ptr_load, ptr_inc;
  logic [7:0]        latch;
  logic              flag;
  logic [ADDR_W-1:0] ptr;

  vdp_addr_latch #(.ADDR_W(ADDR_W)) u_addr_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .latch_we  (latch_we),
    .latch_din (cpu_din),
    .flag_set  (flag_set),
    .flag_clr  (flag_clr),
    .ptr_load  (ptr_load),
    .ptr_hi    (cpu_din[ADDR_W-9:0]),
    .ptr_inc   (ptr_inc),
    .latch     (latch),
    .flag      (flag),
    .ptr       (ptr)
  );

  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    cpu_dout_d  = cpu_dout_q;
    reg_we_d    = 1'b0;
    reg_num_d   = reg_num_q;
    reg_data_d  = reg_data_q;
    status_rd_d = 1'b0;
    latch_we    = 1'b0;
    flag_set    = 1'b0;
    flag_clr    = 1'b0;
    ptr_load    = 1'b0;
    ptr_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          if (cpu_mode) begin
            if (!flag) begin
              latch_we = 1'b1;
              flag_set = 1'b1;
            end else begin
              flag_clr = 1'b1;
              if (cpu_din[CMD_REG]) begin
                reg_we_d   = 1'b1;
                reg_num_d  = cpu_din[REG_W-1:0];
                reg_data_d = latch;
              end else begin
                ptr_load = 1'b1;
                // Read setup primes the buffer so the first data read has data.
                if (!cpu_din[CMD_WR]) begin
                  state_d = FETCH;
                end
              end
            end
          end else begin
            flag_clr = 1'b1;
            wdata_d  = cpu_din;
            state_d  = WRITE;
          end
        end else if (cpu_rd) begin
          flag_clr = 1'b1;
          if (cpu_mode) begin
            cpu_dout_d  = status_in;
            status_rd_d = 1'b1;
          end else begin
            cpu_dout_d = rbuf_q;
            state_d    = FETCH;
          end
        end
      end
      WRITE: begin
        ptr_inc = 1'b1;
`ifdef VDP_WRBUF_EN
        rbuf_d  = wdata_q;
`endif
        state_d = IDLE;
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rbuf_d  = vram_dout;
        ptr_inc = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      cpu_dout_q  <= '0;
      reg_we_q    <= 1'b0;
      reg_num_q   <= '0;
      reg_data_q  <= '0;
      status_rd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      cpu_dout_q  <= cpu_dout_d;
      reg_we_q    <= reg_we_d;
      reg_num_q   <= reg_num_d;
      reg_data_q  <= reg_data_d;
      status_rd_q <= status_rd_d;
    end
  end

  // vram_we decodes straight from state so an asynchronous reset kills it at once.
  assign vram_we   = (state_q == WRITE);
  assign vram_addr = ptr;
  assign vram_din  = wdata_q;
  assign ready     = (state_q == IDLE);
  assign cpu_dout  = cpu_dout_q;
  assign status_rd = status_rd_q;
  assign reg_we    = reg_we_q;
  assign reg_num   = reg_num_q;
  assign reg_data  = reg_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed + randomized bench for vdp_cpu_port against a transaction-level
// model of the VDP CPU port and a behavioural 16K VRAM.
module tb_vdp_cpu_port;

  logic        clk;
  logic        rst_n;
  logic        cpu_wr, cpu_rd, cpu_mode;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        ready;
  logic [7:0]  status_in;
  logic        status_rd;
  logic        reg_we;
  logic [2:0]  reg_num;
  logic [7:0]  reg_data;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_din;
  logic [7:0]  vram_dout;
  logic [1:0]  dbg_state;

  vdp_cpu_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_mode  (cpu_mode),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .ready     (ready),
    .status_in (status_in),
    .status_rd (status_rd),
    .reg_we    (reg_we),
    .reg_num   (reg_num),
    .reg_data  (reg_data),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_din  (vram_din),
    .vram_dout (vram_dout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural VRAM (1-cycle registered read) ----------------
  logic [7:0]  mem [0:16383];
  logic        bd_we;
  logic [13:0] bd_addr;
  logic [7:0]  bd_data;
  int          we_count = 0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (vram_we) mem[vram_addr] <= vram_din;
    vram_dout <= mem[vram_addr];
    if (vram_we) we_count <= we_count + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_mem [0:16383];
  int         m_ptr;
  logic [7:0] m_latch, m_buf, m_dout;
  bit         m_flag;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_latch = 8'h00; m_buf = 8'h00; m_dout = 8'h00; m_flag = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Presents one strobe cycle; returns at the falling edge after the sampling edge.
  task automatic strobe(input logic wr, input logic rd, input logic mode, input logic [7:0] din);
    @(negedge clk);
    cpu_wr = wr; cpu_rd = rd; cpu_mode = mode; cpu_din = din;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  // Counts cycles from the strobe edge until ready; noise keeps strobes asserted while busy.
  task automatic wait_ready(input bit noise, output int n);
    n = 1;
    while (!ready && n < 10) begin
      if (noise) begin
        cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_mode = n[0]; cpu_din = 8'h8E;
      end
      @(negedge clk);
      n++;
    end
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic bd_write(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic ctl_wr(input logic [7:0] b);
    int wc, n;
    logic [7:0] lat;
    wc = we_count;
    lat = m_latch;
    strobe(1'b1, 1'b0, 1'b1, b);
    if (!m_flag) begin
      m_latch = b; m_flag = 1;
      chk("ctl1_reg_we", reg_we, 1'b0);
      chk("ctl1_ready", ready, 1'b1);
    end else begin
      m_flag = 0;
      if (b[7]) begin
        chk("reg_we_pulse", reg_we, 1'b1);
        chk("reg_num", reg_num, b[2:0]);
        chk("reg_data", reg_data, lat);
        chk("reg_ready", ready, 1'b1);
        @(negedge clk);
        chk("reg_we_end", reg_we, 1'b0);
      end else begin
        m_ptr = {b[5:0], lat};
        chk("ctl2_reg_we", reg_we, 1'b0);
        if (b[6]) begin
          chk("wsetup_ready", ready, 1'b1);
          chk("wsetup_ptr", vram_addr, m_ptr);
        end else begin
          m_buf = exp_mem[m_ptr];
          m_ptr = (m_ptr + 1) % 16384;
          wait_ready(1'b0, n);
          chk("prefetch_lat", n, 3);
          chk("prefetch_ptr", vram_addr, m_ptr);
        end
      end
    end
    chk("ctl_no_vram_we", we_count, wc);
  endtask

  task automatic data_wr(input logic [7:0] b, input logic also_rd);
    int wc, n, old;
    wc = we_count;
    old = m_ptr;
    strobe(1'b1, also_rd, 1'b0, b);
    chk("wr_vram_we", vram_we, 1'b1);
    chk("wr_addr", vram_addr, old);
    chk("wr_din", vram_din, b);
    chk("wr_busy", ready, 1'b0);
    wait_ready(1'b0, n);
    chk("wr_lat", n, 2);
    chk("wr_we_once", we_count, wc + 1);
    chk("wr_mem", mem[old], b);
    m_flag = 0;
    exp_mem[old] = b;
    m_ptr = (m_ptr + 1) % 16384;
`ifdef VDP_WRBUF_EN
    m_buf = b;
`endif
    chk("wr_ptr_inc", vram_addr, m_ptr);
    chk("wr_dout_kept", cpu_dout, m_dout);
  endtask

  task automatic data_rd(input bit noise);
    int wc, n;
    logic [7:0] exp;
    wc = we_count;
    exp = m_buf;
    m_dout = exp;
    strobe(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rd_dout", cpu_dout, exp);
    chk("rd_busy", ready, 1'b0);
    m_flag = 0;
    m_buf = exp_mem[m_ptr];
    m_ptr = (m_ptr + 1) % 16384;
    wait_ready(noise, n);
    chk("rd_lat", n, 3);
    chk("rd_ptr", vram_addr, m_ptr);
    chk("rd_no_we", we_count, wc);
  endtask

  task automatic stat_rd(input logic [7:0] s);
    int wc;
    wc = we_count;
    status_in = s;
    strobe(1'b0, 1'b1, 1'b1, 8'h00);
    chk("stat_dout", cpu_dout, s);
    chk("stat_rd_pulse", status_rd, 1'b1);
    chk("stat_ready", ready, 1'b1);
    @(negedge clk);
    chk("stat_rd_end", status_rd, 1'b0);
    chk("stat_no_we", we_count, wc);
    m_dout = s;
    m_flag = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_dout"}, cpu_dout, 8'h00);
    chk({tag, "_vram_we"}, vram_we, 1'b0);
    chk({tag, "_vram_addr"}, vram_addr, 14'h0000);
    chk({tag, "_vram_din"}, vram_din, 8'h00);
    chk({tag, "_reg_we"}, reg_we, 1'b0);
    chk({tag, "_reg_num"}, reg_num, 3'd0);
    chk({tag, "_reg_data"}, reg_data, 8'h00);
    chk({tag, "_status_rd"}, status_rd, 1'b0);
    chk({tag, "_state"}, dbg_state, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] want;
    int old;
    rst_n = 1'b0;
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_mode = 1'b0; cpu_din = 8'h00;
    status_in = 8'h00;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    model_reset();

    // Fill VRAM with random contents while the DUT is held in reset.
    for (int i = 0; i < 16384; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 14'(i); bd_data = 8'($urandom_range(0, 255));
      exp_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Write setup to 0x0034, then one data write.
    ctl_wr(8'h34);
    ctl_wr(8'h40);
    chk("setup_0034", vram_addr, 14'h0034);
    data_wr(8'hA5, 1'b0);
    chk("mem_0034", mem[14'h0034], 8'hA5);

    // Read setup with prefetch from 0x1000.
    bd_write(14'h1000, 8'h11);
    bd_write(14'h1001, 8'h22);
    ctl_wr(8'h00);
    ctl_wr(8'h10);
    data_rd(1'b0);
    chk("rd1_is_11", cpu_dout, 8'h11);
    chk("ptr_1002", vram_addr, 14'h1002);
    data_rd(1'b0);
    chk("rd2_is_22", cpu_dout, 8'h22);

    // Register write R7 <= 0x5A.
    ctl_wr(8'h5A);
    ctl_wr(8'h87);

    // Pointer wrap at the top of VRAM.
    ctl_wr(8'hFF);
    ctl_wr(8'h7F);
    chk("setup_3fff", vram_addr, 14'h3FFF);
    data_wr(8'h01, 1'b0);
    data_wr(8'h02, 1'b0);
    chk("mem_3fff", mem[14'h3FFF], 8'h01);
    chk("mem_0000", mem[14'h0000], 8'h02);

    // Status read clears the byte flag; next control byte is a first byte.
    ctl_wr(8'h12);
    stat_rd(8'h80);
    ctl_wr(8'h99);
    ctl_wr(8'h40);
    chk("after_stat_ptr", vram_addr, 14'h0099);

    // Coincident write+read: write taken, read dropped.
    data_wr(8'h3C, 1'b1);

    // Strobes while busy are ignored.
    data_rd(1'b1);
    ctl_wr(8'h00);
    ctl_wr(8'h48);
    chk("busy_ignored_ptr", vram_addr, 14'h0800);

    // Read buffer behaviour after a data write.
    ctl_wr(8'h00);
    ctl_wr(8'h20);
`ifdef VDP_WRBUF_EN
    want = 8'h77;
`else
    want = exp_mem[14'h2000];
`endif
    data_wr(8'h77, 1'b0);
    data_rd(1'b0);
    chk("wrbuf_rd", cpu_dout, want);

    // Reset in the middle of a write.
    ctl_wr(8'h00);
    ctl_wr(8'h55);
    old = m_ptr;
    strobe(1'b1, 1'b0, 1'b0, 8'hC3);
    chk("midrst_we_before", vram_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we_drop", vram_we, 1'b0);
    chk("midrst_ptr", vram_addr, 14'h0000);
    chk("midrst_ready", ready, 1'b1);
    model_reset();
    @(negedge clk);
    chk("midrst_write_lost", mem[old], exp_mem[old]);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) ctl_wr(8'($urandom_range(0, 255)));
      else if (r <= 5) data_wr(8'($urandom_range(0, 255)), (r == 5));
      else if (r <= 8) data_rd(r == 8);
      else stat_rd(8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
